muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit unsigned multiply/divide execution unit. It sits between the register bank's read ports and its single write port. It captures two operands and a destination index on `start`, computes over 32 cycles, and presents the result on a valid/ready write-back interface. A write-back arbiter merges that interface with the single-cycle ALU path into `write`/`write_index`/`write_en`.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 4.
- `clk` input 1: clock, rising-edge.
- `rst_async` input 1: reset, asynchronous, active-high.
- `start` input 1: request a new operation; accepted only when `busy`=0 (or in the DONE-handoff cycle, see Operation).
- `op` input 2: 0=MUL (low 32 of product), 1=MULHU (high 32 of unsigned product), 2=DIVU (quotient), 3=REMU (remainder).
- `a` input 32: operand A / dividend; sampled on accept.
- `b` input 32: operand B / divisor; sampled on accept.
- `dest` input 4: destination register index; sampled on accept.
- `flush` input 1: abort any in-flight or pending operation.
- `busy` output 1: high in RUN and DONE states.
- `wb_valid` output 1: result available (DONE state).
- `wb_index` output 4: captured `dest`, stable while `wb_valid`.
- `wb_data` output 32: result, stable while `wb_valid`.
- `wb_ready` input 1: arbiter accepts result this cycle.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. The 6-bit iteration counter is 0, and operand, accumulator, `wb_index` and `wb_data` registers are 0; `busy`=0, `wb_valid`=0.
- IDLE: `start`=1 and `flush`=0 → capture `op`, `a`, `b`, `dest`; load counter with 32; go to RUN.
- RUN: one iteration per cycle, counter decrements; at counter==1 the final iteration completes and the state moves to DONE. Exactly 32 RUN cycles.
- Multiply: shift-add over a 64-bit accumulator, treating `b` as the multiplier LSB-first. MUL returns product[31:0]; MULHU returns product[63:32].
- Divide: restoring, 32 quotient bits MSB-first, 33-bit partial remainder. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (`b`==0 captured): DIVU result 0xFFFFFFFF, REMU result = `a`. The full 32 cycles are still spent, so latency is constant.
- DONE: `wb_valid`=1; `wb_index`/`wb_data` are held until `wb_ready`=1.
  - `wb_ready`=1 with `start`=0 → IDLE.
  - `wb_ready`=1 with `start`=1 → capture the new operation and go directly to RUN (back-to-back, no bubble).
  - `wb_ready`=0 → `start` is ignored.
- `start` in RUN, or in DONE without `wb_ready`, is ignored. There is no queueing; upstream must stall on `busy`.
- `flush`=1 in any state → IDLE next cycle. The result is discarded and `wb_valid` drops. Flush has priority over `start` and `wb_ready` in the same cycle. A result handshaken in the same cycle as `flush` counts as not delivered.
- `dest`==0 is not special-cased: the result is presented normally, and the register bank discards writes to index 0.
- `rst_async` mid-operation: all state clears immediately, outputs go to reset values, and no result is produced.

## Timing
- Accept at edge E0 (`start` sampled in IDLE). `busy`=1 from E0; RUN spans E0..E32. `wb_valid`=1 after E32, so the result is visible 33 cycles after the `start` cycle.
- Handshake completes on the edge where `wb_valid`=1 and `wb_ready`=1. `wb_valid` deasserts after that edge unless a back-to-back start was accepted; in that case `busy` stays 1 and `wb_valid` is 0.
- Back-to-back throughput: one result per 33 cycles.
- Outputs are registered; there is no combinational path from `wb_ready`, `start` or `flush` to any output.

## Test plan
- Reset then MUL: a=0x0001_0003, b=0x0000_0005, dest=3 → after 33 cycles `wb_valid`=1, `wb_index`=3, `wb_data`=0x0005_000F; `busy` is high for exactly 33 cycles, including the handshake cycle.
- MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `wb_data`=0xFFFF_FFFE; MUL with the same operands → 0x0000_0001.
- DIVU a=100, b=7 → 14; REMU a=100, b=7 → 2; DIVU b=0 → 0xFFFF_FFFF; REMU a=0x1234, b=0 → 0x1234.
- Backpressure: hold `wb_ready`=0 for 10 cycles after `wb_valid`; pulse `start` meanwhile → data and index stay stable and the extra `start` is ignored. Then assert `wb_ready` together with `start`(DIVU 9/3) → the first result is taken, and the next result 3 appears 33 cycles later.
- Flush at RUN cycle 16, and separately in DONE with `wb_ready`=1 and `start`=1 → IDLE next cycle, `wb_valid` never asserts or drops, and the `start` is not accepted.
- Assert `rst_async` mid-RUN → `busy` and `wb_valid` drop asynchronously. A fresh MUL 6×7 after release yields 42.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Bundle between the register-bank read ports, the multiply/divide unit and
// the write-back arbiter.
interface muldiv_unit_if;
  // Request side: start is taken in a cycle where busy=0 (or on the DONE
  // handoff edge with wb_ready=1); otherwise it is dropped, never queued.
  // Result side: valid/ready. Once wb_valid rises, wb_index and wb_data stay
  // stable until the edge where wb_valid=1 and wb_ready=1. flush in that same
  // cycle cancels the transfer. wb_ready has no effect while wb_valid=0.
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  dest;
  logic        flush;
  logic        busy;
  logic        wb_valid;
  logic [3:0]  wb_index;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic [1:0]  state_dbg;

  modport master (
    output start, op, a, b, dest, flush, wb_ready,
    input  busy, wb_valid, wb_index, wb_data, state_dbg
  );

  modport slave (
    input  start, op, a, b, dest, flush, wb_ready,
    output busy, wb_valid, wb_index, wb_data, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit: 32 iterations per operation,
// with the result handed to the write-back arbiter over a valid/ready port.
module muldiv_unit (
  input  logic          clk,
  input  logic          rst_async,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] opnd_q;
  logic [32:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q, valid_q;
  logic [3:0]  index_q;
  logic [31:0] data_q;

  logic        accept;
  logic        last_iter;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [32:0] hi_step;
  logic [31:0] lo_step;
  logic [31:0] result;

  assign last_iter = (cnt == 6'd1);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.wb_ready) begin
          accept     = bus.start;
          state_next = bus.start ? S_RUN : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Flush beats both a new start and a handshake in the same cycle.
    if (bus.flush) begin
      accept     = 1'b0;
      state_next = S_IDLE;
    end
  end

  // hi_q/lo_q form one 65-bit working register. Multiply: hi accumulates the
  // partial product while lo shifts the multiplier out LSB-first and product
  // bits in from the top. Divide: hi is the partial remainder, lo shifts the
  // dividend out MSB-first and quotient bits in from the bottom.
  always_comb begin
    mul_sum   = hi_q + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {hi_q[31:0], lo_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (op_q[1]) begin
      hi_step = div_ge ? div_diff : div_shift;
      lo_step = {lo_q[30:0], div_ge};
    end else begin
      hi_step = {1'b0, mul_sum[32:1]};
      lo_step = {mul_sum[0], lo_q[31:1]};
    end
    case (op_q)
      2'd0:    result = lo_step;
      2'd1:    result = hi_step[31:0];
      2'd2:    result = lo_step;
      default: result = hi_step[31:0];
    endcase
  end

  // A zero divisor needs no special case: every trial subtraction succeeds,
  // so the quotient fills with ones and the remainder ends up equal to a.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      cnt     <= 6'd0;
      op_q    <= 2'd0;
      opnd_q  <= 32'd0;
      hi_q    <= 33'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      index_q <= 4'd0;
      data_q  <= 32'd0;
    end else begin
      busy_q  <= (state_next != S_IDLE);
      valid_q <= (state_next == S_DONE);
      if (bus.flush) begin
        cnt <= 6'd0;
      end else if (accept) begin
        cnt     <= 6'd32;
        op_q    <= bus.op;
        opnd_q  <= bus.op[1] ? bus.b : bus.a;
        lo_q    <= bus.op[1] ? bus.a : bus.b;
        hi_q    <= 33'd0;
        index_q <= bus.dest;
      end else if (state == S_RUN) begin
        cnt  <= cnt - 6'd1;
        hi_q <= hi_step;
        lo_q <= lo_step;
        if (last_iter) data_q <= result;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.wb_valid  = valid_q;
  assign bus.wb_index  = index_q;
  assign bus.wb_data   = data_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic
// reference model, with a scoreboard of expected {index, data} results.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_async;
  muldiv_unit_if mif ();

  muldiv_unit dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (mif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] dest);
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    mif.dest  = dest;
    tick();
    mif.start = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
    mif.dest  = 4'($urandom);
    exp_q.push_back({dest, ref_res(op, a, b)});
  endtask

  task automatic wait_valid(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!mif.wb_valid && lat < 100) begin
      if (mif.busy) busy_n++;
      tick();
      lat++;
    end
    if (mif.busy) busy_n++;
    check("latency", 32'(lat), 32'd32);
  endtask

  task automatic take(input string tag);
    logic [35:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'h0;
    check({tag, "_valid"}, 32'(mif.wb_valid), 32'd1);
    check({tag, "_data"}, mif.wb_data, e[31:0]);
    check({tag, "_index"}, 32'(mif.wb_index), 32'(e[35:32]));
    mif.wb_ready = 1'b1;
    tick();
    mif.wb_ready = 1'b0;
    check({tag, "_drop"}, 32'(mif.wb_valid), 32'd0);
    check({tag, "_idle"}, 32'(mif.busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] dest);
    int lat, bn;
    issue(op, a, b, dest);
    wait_valid(lat, bn);
    take(tag);
  endtask

  initial begin
    int lat, bn, seen;
    logic [35:0] held;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    mif.start    = 1'b0;
    mif.op       = 2'd0;
    mif.a        = 32'd0;
    mif.b        = 32'd0;
    mif.dest     = 4'd0;
    mif.flush    = 1'b0;
    mif.wb_ready = 1'b0;
    rst_async    = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_async = 1'b0;
    tick();

    check("rst_busy", 32'(mif.busy), 32'd0);
    check("rst_valid", 32'(mif.wb_valid), 32'd0);
    check("rst_index", 32'(mif.wb_index), 32'd0);
    check("rst_data", mif.wb_data, 32'd0);

    // First MUL: fixed latency and busy width, plus a hard-coded expectation.
    issue(2'd0, 32'h0001_0003, 32'h0000_0005, 4'd3);
    wait_valid(lat, bn);
    check("mul_busy_cycles", 32'(bn), 32'd33);
    check("mul_const", mif.wb_data, 32'h0005_000F);
    take("mul");

    run_op("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
    run_op("mul_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    run_op("divu", 2'd2, 32'd100, 32'd7, 4'd4);
    run_op("remu", 2'd3, 32'd100, 32'd7, 4'd5);
    run_op("divu_zero", 2'd2, 32'd55, 32'd0, 4'd6);
    run_op("remu_zero", 2'd3, 32'h1234, 32'd0, 4'd0);

    // Backpressure with an ignored start, then back-to-back handoff.
    issue(2'd0, 32'd1234, 32'd5678, 4'd7);
    wait_valid(lat, bn);
    held = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        mif.start = 1'b1;
        mif.op    = 2'd3;
        mif.a     = 32'd99;
        mif.b     = 32'd5;
        mif.dest  = 4'd9;
      end
      tick();
      mif.start = 1'b0;
      check("bp_data", mif.wb_data, held[31:0]);
      check("bp_index", 32'(mif.wb_index), 32'(held[35:32]));
      check("bp_valid", 32'(mif.wb_valid), 32'd1);
    end
    mif.wb_ready = 1'b1;
    check("b2b_first_data", mif.wb_data, held[31:0]);
    issue(2'd2, 32'd9, 32'd3, 4'd5);
    mif.wb_ready = 1'b0;
    void'(exp_q.pop_front());
    check("b2b_valid_low", 32'(mif.wb_valid), 32'd0);
    check("b2b_busy", 32'(mif.busy), 32'd1);
    wait_valid(lat, bn);
    check("b2b_const", mif.wb_data, 32'd3);
    take("b2b");

    // Flush at RUN cycle 16.
    issue(2'd0, 32'd3, 32'd4, 4'd1);
    repeat (15) tick();
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_run_busy", 32'(mif.busy), 32'd0);
    check("flush_run_valid", 32'(mif.wb_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (mif.wb_valid) seen++;
    end
    check("flush_run_never_valid", 32'(seen), 32'd0);

    // Flush in DONE with a handshake and a start in the same cycle.
    issue(2'd2, 32'd100, 32'd7, 4'd2);
    wait_valid(lat, bn);
    mif.flush    = 1'b1;
    mif.wb_ready = 1'b1;
    mif.start    = 1'b1;
    mif.op       = 2'd0;
    mif.a        = 32'd6;
    mif.b        = 32'd7;
    mif.dest     = 4'd1;
    tick();
    mif.flush    = 1'b0;
    mif.wb_ready = 1'b0;
    mif.start    = 1'b0;
    exp_q.delete();
    check("flush_done_valid", 32'(mif.wb_valid), 32'd0);
    check("flush_done_busy", 32'(mif.busy), 32'd0);
    repeat (5) tick();
    check("flush_done_no_start", 32'(mif.busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    issue(2'd1, $urandom, $urandom, 4'd8);
    repeat (10) tick();
    #2 rst_async = 1'b1;
    #1;
    check("arst_busy", 32'(mif.busy), 32'd0);
    check("arst_valid", 32'(mif.wb_valid), 32'd0);
    check("arst_data", mif.wb_data, 32'd0);
    exp_q.delete();
    #3 rst_async = 1'b0;
    tick();
    issue(2'd0, 32'd6, 32'd7, 4'd4);
    wait_valid(lat, bn);
    check("arst_mul42", mif.wb_data, 32'd42);
    take("arst_mul");

    // Randomized operations with random write-back stalls.
    for (int n = 0; n < 25; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 4'($urandom_range(0, 15)));
      wait_valid(lat, bn);
      repeat ($urandom_range(0, 3)) tick();
      take("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
